// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   BE_WORD     : byte-enable pattern for a full-word access
//   REQ_IF/MEM  : requester identifiers
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_IF  = 2'd1,
    ACC_MEM = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic       REQ_IF  = 1'b0;
  localparam logic       REQ_MEM = 1'b1;

endpackage

// File: rtl/byte_lane_gen.sv
// Byte-lane mapper for RAM writes.
// Ports:
//   addr_lo    in  2   low address bits of the access
//   we         in  1   store access
//   byte_en    in  1   byte store (Store_Byte)
//   wdata      in  32  store data from the requester
//   be         out 4   RAM byte enables
//   wdata_lane out 32  RAM write data, byte replicated across lanes for byte stores
module byte_lane_gen
  import mips_pipe_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic        byte_en,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane
);

  always_comb begin
    be         = BE_WORD;
    wdata_lane = wdata;
    if (we && byte_en) begin
      be         = 4'b0001 << addr_lo;
      wdata_lane = {4{wdata[7:0]}};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported RAM between the fetch (IF) and memory (MEM)
// requesters. Each transfer runs WAIT_CYCLES access cycles followed by a
// one-cycle ack. MEM wins ties unless IF has lost STARVE_MAX consecutive ties.
//
// Optional build macro: MEM_PORT_MISALIGN_TRAP_EN
//   Adds mem_misalign; misaligned MEM word accesses never write the RAM and
//   flag mem_misalign together with mem_ack.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   if_req/if_addr        fetch request (held until if_ack) and address
//   if_rdata/if_ack       fetched word and its one-cycle ack
//   mem_req/mem_we/mem_byte/mem_addr/mem_wdata  MEM request from EXE/MEM
//   mem_rdata/mem_ack     load word and its one-cycle ack
//   stall_if/stall_mem    pipeline hold enables (combinational)
//   ram_*                 RAM interface; ram_rdata valid on last access cycle
//   mem_misalign          (optional) misaligned word access flag
//
// state   | meaning
// IDLE    | arbitrate between pending requests
// ACC_IF  | RAM access on behalf of IF, counting down wait_cnt
// ACC_MEM | RAM access on behalf of MEM, counting down wait_cnt
// DONE    | ack cycle for the granted requester; no arbitration
module mem_port_arbiter
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_byte,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_PORT_MISALIGN_TRAP_EN
  ,
  output logic              mem_misalign
`endif
);

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state, state_n;
  logic [3:0]        starve_cnt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic              lat_byte;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_mis;
  logic              grant_if, grant_mem;
  logic              acc;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic              mis_now;

  // Misaligned word access: only meaningful when the trap is built in.
`ifdef MEM_PORT_MISALIGN_TRAP_EN
  assign mis_now = !mem_byte && (mem_addr[1:0] != 2'b00);
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && (!mem_req || starve_cnt == STARVE_LIM)) begin
          grant_if = 1'b1;
          state_n  = ACC_IF;
        end else if (mem_req) begin
          grant_mem = 1'b1;
          state_n   = ACC_MEM;
        end
      end
      ACC_IF, ACC_MEM: begin
        if (wait_cnt == 4'd0) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign acc = (state == ACC_IF) || (state == ACC_MEM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      wait_cnt   <= 4'd0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_byte   <= 1'b0;
      lat_wdata  <= '0;
      lat_mis    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
    end else begin
      state   <= state_n;
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      if (grant_if) begin
        lat_addr   <= if_addr;
        lat_we     <= 1'b0;
        lat_byte   <= 1'b0;
        lat_wdata  <= '0;
        lat_mis    <= 1'b0;
        wait_cnt   <= WAIT_LOAD;
        starve_cnt <= 4'd0;
      end
      if (grant_mem) begin
        lat_addr  <= mem_addr;
        lat_we    <= mem_we;
        lat_byte  <= mem_byte;
        lat_wdata <= mem_wdata;
        lat_mis   <= mis_now;
        wait_cnt  <= WAIT_LOAD;
        if (if_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end
      if (acc) begin
        if (wait_cnt != 4'd0) begin
          wait_cnt <= wait_cnt - 4'd1;
        end else if (state == ACC_IF) begin
          if_rdata <= ram_rdata;
          if_ack   <= 1'b1;
        end else begin
          mem_rdata <= ram_rdata;
          mem_ack   <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_PORT_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_misalign <= 1'b0;
    else        mem_misalign <= (state == ACC_MEM) && (wait_cnt == 4'd0) && lat_mis;
  end
`endif

  byte_lane_gen u_lanes (
    .addr_lo    (lat_addr[1:0]),
    .we         (lat_we),
    .byte_en    (lat_byte),
    .wdata      (lat_wdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata)
  );

  // RAM outputs are gated by the access window so they read zero in IDLE/DONE
  // and fall as soon as reset forces the state back to IDLE.
  assign ram_en    = acc;
  assign ram_we    = acc && lat_we && !lat_mis;
  assign ram_be    = acc ? lane_be : 4'h0;
  assign ram_addr  = acc ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign ram_wdata = acc ? lane_wdata : '0;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mips_pipe_pkg::*;

  localparam int SMAX = 4;
  localparam int W3   = 3;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Instance a: WAIT_CYCLES=1 ; instance b: WAIT_CYCLES=3
  logic        a_rst_n, a_if_req, a_if_ack, a_mem_req, a_mem_we, a_mem_byte, a_mem_ack;
  logic        a_stall_if, a_stall_mem, a_ram_en, a_ram_we, a_mis;
  logic [31:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_ram_be;
  logic        b_rst_n, b_if_req, b_if_ack, b_mem_req, b_mem_we, b_mem_byte, b_mem_ack;
  logic        b_stall_if, b_stall_mem, b_ram_en, b_ram_we, b_mis;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_be;

  assign a_ram_rdata = ram_word(a_ram_addr);
  assign b_ram_rdata = ram_word(b_ram_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rst_n(a_rst_n), .if_req(a_if_req), .if_addr(a_if_addr),
    .if_rdata(a_if_rdata), .if_ack(a_if_ack), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_byte(a_mem_byte), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack), .stall_if(a_stall_if),
    .stall_mem(a_stall_mem), .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_be(a_ram_be),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    , .mem_misalign(a_mis)
`endif
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W3), .STARVE_MAX(SMAX)) u3 (
    .clk(clk), .rst_n(b_rst_n), .if_req(b_if_req), .if_addr(b_if_addr),
    .if_rdata(b_if_rdata), .if_ack(b_if_ack), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_byte(b_mem_byte), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack), .stall_if(b_stall_if),
    .stall_mem(b_stall_mem), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_be(b_ram_be),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    , .mem_misalign(b_mis)
`endif
  );

`ifndef MEM_PORT_MISALIGN_TRAP_EN
  assign a_mis = 1'b0;
  assign b_mis = 1'b0;
`endif

  // reference-model and bookkeeping variables
  int          scnt, g, nxt, a_start, a_end, ack_c;
  bit          who, got, exp_who, ack_due, exp_en, exp_ia, exp_ma;
  bit          g_we, g_byte, g_mis;
  bit          pend_if, pend_mem;
  logic [31:0] g_addr, g_wdata, exp_wd;
  logic [3:0]  exp_be;

  initial begin
    a_rst_n = 0; b_rst_n = 0;
    a_if_req = 0; a_if_addr = 0; a_mem_req = 0; a_mem_we = 0; a_mem_byte = 0;
    a_mem_addr = 0; a_mem_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_mem_req = 0; b_mem_we = 0; b_mem_byte = 0;
    b_mem_addr = 0; b_mem_wdata = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_mem_ack", a_mem_ack, 0);
    chk("rst_if_ack", a_if_ack, 0);
    chk("rst_mem_rdata", a_mem_rdata, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_ram_en", a_ram_en, 0);
    chk("rst_ram_we", a_ram_we, 0);
    chk("rst_ram_be", a_ram_be, 0);
    chk("rst_ram_addr", a_ram_addr, 0);
    chk("rst_ram_wdata", a_ram_wdata, 0);
    a_rst_n = 1; b_rst_n = 1;
    @(negedge clk);

    // single MEM load, W=1
    a_mem_req = 1; a_mem_we = 0; a_mem_addr = 32'h10; #1;
    chk("ld_c0_stall", a_stall_mem, 1);
    chk("ld_c0_en", a_ram_en, 0);
    @(negedge clk);
    chk("ld_c1_en", a_ram_en, 1);
    chk("ld_c1_addr", a_ram_addr, 32'h10);
    chk("ld_c1_be", a_ram_be, 4'hF);
    chk("ld_c1_we", a_ram_we, 0);
    chk("ld_c1_ack", a_mem_ack, 0);
    chk("ld_c1_stall", a_stall_mem, 1);
    @(negedge clk);
    chk("ld_c2_ack", a_mem_ack, 1);
    chk("ld_c2_rdata", a_mem_rdata, 32'hDEADBEEF);
    chk("ld_c2_stall", a_stall_mem, 0);
    chk("ld_c2_en", a_ram_en, 0);
    a_mem_req = 0;
    @(negedge clk);
    chk("ld_c3_ack", a_mem_ack, 0);
    chk("ld_hold_rdata", a_mem_rdata, 32'hDEADBEEF);

    // byte store to 0x13
    a_mem_req = 1; a_mem_we = 1; a_mem_byte = 1; a_mem_addr = 32'h13; a_mem_wdata = 32'hA5;
    @(negedge clk);
    chk("sb_we", a_ram_we, 1);
    chk("sb_be", a_ram_be, 4'b1000);
    chk("sb_wdata", a_ram_wdata, 32'hA5A5A5A5);
    chk("sb_addr", a_ram_addr, 32'h10);
    @(negedge clk);
    chk("sb_ack", a_mem_ack, 1);
    a_mem_req = 0;
    @(negedge clk);

    // misaligned word store to 0x22
    a_mem_req = 1; a_mem_we = 1; a_mem_byte = 0; a_mem_addr = 32'h22; a_mem_wdata = 32'h12345678;
    @(negedge clk);
    chk("mis_en", a_ram_en, 1);
    chk("mis_we", a_ram_we, TRAP ? 1'b0 : 1'b1);
    chk("mis_addr", a_ram_addr, 32'h20);
    chk("mis_be", a_ram_be, 4'hF);
    @(negedge clk);
    chk("mis_ack", a_mem_ack, 1);
    chk("mis_flag", a_mis, TRAP);
    chk("mis_we_done", a_ram_we, 0);
    a_mem_req = 0; a_mem_we = 0;
    @(negedge clk);
    chk("mis_flag_clr", a_mis, 0);
    chk("mis_ack_clr", a_mem_ack, 0);

    // both held continuously: starvation rotation
    a_if_req = 1; a_if_addr = 32'h100; a_mem_req = 1; a_mem_addr = 32'h200;
    scnt = 0; g = 0; ack_due = 0; who = 0;
    for (int k = 0; k < 200 && g < 10; k++) begin
      @(negedge clk);
      if (ack_due) begin
        chk("starve_ack", who ? a_mem_ack : a_if_ack, 1);
        ack_due = 0;
      end
      if (a_ram_en) begin
        if (scnt == SMAX) begin exp_who = 0; scnt = 0; end
        else begin exp_who = 1; scnt = scnt + 1; end
        got = (a_ram_addr == 32'h200);
        chk($sformatf("starve_order%0d", g), got, exp_who);
        if (!exp_who) chk("starve_cnt_clr", 32'(u1.starve_cnt), 0);
        who = exp_who; ack_due = 1; g++;
      end
    end
    chk("starve_grants", g, 10);
    @(negedge clk);
    if (ack_due) chk("starve_last_ack", who ? a_mem_ack : a_if_ack, 1);
    a_if_req = 0; a_mem_req = 0;
    @(negedge clk);

    // back-to-back IF held through ack, W=3
    b_if_req = 1; b_if_addr = 32'h40;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      exp_ia = (c >= 4) && ((c - 4) % 5 == 0);
      exp_en = (c % 5 >= 1) && (c % 5 <= 3);
      chk($sformatf("b2b_ack_c%0d", c), b_if_ack, exp_ia);
      chk($sformatf("b2b_en_c%0d", c), b_ram_en, exp_en);
      chk($sformatf("b2b_stall_c%0d", c), b_stall_if, !exp_ia);
      if (exp_ia) chk("b2b_rdata", b_if_rdata, ram_word(32'h40));
    end
    b_if_req = 0;
    @(negedge clk);

    // reset in the 2nd access cycle of a store
    b_mem_req = 1; b_mem_we = 1; b_mem_byte = 0; b_mem_addr = 32'h30; b_mem_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rs_acc1_we", b_ram_we, 1);
    @(negedge clk);
    chk("rs_acc2_en", b_ram_en, 1);
    b_rst_n = 0; #1;
    chk("rs_we_drop", b_ram_we, 0);
    chk("rs_en_drop", b_ram_en, 0);
    chk("rs_state", 32'(u3.state), 32'(IDLE));
    chk("rs_ack", b_mem_ack, 0);
    chk("rs_stall", b_stall_mem, 1);
    repeat (2) begin
      @(negedge clk);
      chk("rs_hold_ack", b_mem_ack, 0);
    end
    b_rst_n = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("rs_re_en_c%0d", c), b_ram_en, c <= 3);
      chk($sformatf("rs_re_we_c%0d", c), b_ram_we, c <= 3);
      chk($sformatf("rs_re_ack_c%0d", c), b_mem_ack, c == 4);
    end
    b_mem_req = 0; b_mem_we = 0;
    @(negedge clk);

    // randomized traffic against a transaction-level model, W=3
    scnt = 0; nxt = 0; a_start = -1; a_end = -1; ack_c = -1; who = 0;
    pend_if = 0; pend_mem = 0;
    g_addr = 0; g_wdata = 0; g_we = 0; g_byte = 0; g_mis = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_en = (c >= a_start) && (c <= a_end);
      chk("rnd_en", b_ram_en, exp_en);
      if (exp_en) begin
        exp_be = (g_we && g_byte) ? (4'b0001 << g_addr[1:0]) : 4'hF;
        exp_wd = (g_we && g_byte) ? {4{g_wdata[7:0]}} : g_wdata;
        chk("rnd_addr", b_ram_addr, {g_addr[31:2], 2'b00});
        chk("rnd_we", b_ram_we, g_we && !g_mis);
        chk("rnd_be", b_ram_be, exp_be);
        if (g_we) chk("rnd_wdata", b_ram_wdata, exp_wd);
      end
      exp_ia = (c == ack_c) && !who;
      exp_ma = (c == ack_c) && who;
      chk("rnd_if_ack", b_if_ack, exp_ia);
      chk("rnd_mem_ack", b_mem_ack, exp_ma);
      chk("rnd_stall_if", b_stall_if, b_if_req && !exp_ia);
      chk("rnd_stall_mem", b_stall_mem, b_mem_req && !exp_ma);
      chk("rnd_mis", b_mis, exp_ma && g_mis);
      if (exp_ia) begin
        chk("rnd_if_rdata", b_if_rdata, ram_word({g_addr[31:2], 2'b00}));
        pend_if = 0; b_if_req = 0;
      end
      if (exp_ma) begin
        if (!g_we) chk("rnd_mem_rdata", b_mem_rdata, ram_word({g_addr[31:2], 2'b00}));
        pend_mem = 0; b_mem_req = 0;
      end
      if (c < 340) begin
        if (!pend_if && $urandom_range(0, 2) != 0) begin
          pend_if = 1; b_if_req = 1; b_if_addr = $urandom & 32'h0000_0FFC;
        end
        if (!pend_mem && $urandom_range(0, 2) != 0) begin
          pend_mem = 1; b_mem_req = 1;
          b_mem_we = 1'($urandom); b_mem_byte = 1'($urandom);
          b_mem_addr = $urandom & 32'h0000_0FFF; b_mem_wdata = $urandom;
        end
      end
      if (c >= nxt && (b_if_req || b_mem_req)) begin
        if (b_if_req && (!b_mem_req || scnt == SMAX)) begin
          who = 0; scnt = 0;
          g_addr = b_if_addr; g_we = 0; g_byte = 0; g_mis = 0; g_wdata = 0;
        end else begin
          who = 1;
          if (b_if_req && scnt < SMAX) scnt = scnt + 1;
          g_addr = b_mem_addr; g_we = b_mem_we; g_byte = b_mem_byte; g_wdata = b_mem_wdata;
          g_mis = TRAP && !b_mem_byte && (b_mem_addr[1:0] != 2'b00);
        end
        a_start = c + 1; a_end = c + W3; ack_c = c + W3 + 1; nxt = c + W3 + 2;
      end
    end
    chk("rnd_drained", {30'd0, pend_if, pend_mem}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
